// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared datapath widths and register-file constants
package cpu_pkg;

    localparam int CPU_DATA_W = 32;
    localparam int CPU_ADDR_W = 5;

    // Architectural zero register index
    localparam logic [CPU_ADDR_W-1:0] REG_ZERO = '0;

    // True when addr names the hardwired zero register and that feature is enabled
    function automatic logic is_zero_reg(input logic [CPU_ADDR_W-1:0] addr, input int zero_reg);
        return (zero_reg != 0) && (addr == REG_ZERO);
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - per-register pending-write scoreboard with same-cycle writeback release
module rf_scoreboard
    import cpu_pkg::*;
#(
    parameter int ADDR_W   = CPU_ADDR_W,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    input  logic              wr0_en,
    input  logic [ADDR_W-1:0] wr0_addr,
    input  logic              wr1_en,
    input  logic [ADDR_W-1:0] wr1_addr,
    input  logic              iss_en,
    input  logic [ADDR_W-1:0] iss_addr,
    input  logic              flush,
    output logic              busy_a,
    output logic              busy_b
);

    localparam int NREGS = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

    logic [NREGS-1:0] pending_q;
    logic [NREGS-1:0] pending_d;
    logic             wr_hit_a;
    logic             wr_hit_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    // Clear on writeback, then a newly issued producer wins, then flush wins over all
    always_comb begin
        pending_d = pending_q;
        if (wr0_en) begin
            pending_d[wr0_addr] = 1'b0;
        end
        if (wr1_en) begin
            pending_d[wr1_addr] = 1'b0;
        end
        if (iss_en) begin
            pending_d[iss_addr] = 1'b1;
        end
        if (flush) begin
            pending_d = '0;
        end
        if (ZERO_REG != 0) begin
            pending_d[ZERO_ADDR] = 1'b0;
        end
    end

    always_comb begin
        wr_hit_a = (wr0_en && (wr0_addr == rd_addr_a)) || (wr1_en && (wr1_addr == rd_addr_a));
        wr_hit_b = (wr0_en && (wr0_addr == rd_addr_b)) || (wr1_en && (wr1_addr == rd_addr_b));
        if (BYPASS == 0) begin
            wr_hit_a = 1'b0;
            wr_hit_b = 1'b0;
        end
        busy_a = rst_n && pending_q[rd_addr_a] && !wr_hit_a;
        busy_b = rst_n && pending_q[rd_addr_b] && !wr_hit_b;
    end

endmodule

// File: rtl/pipe_reg_file.sv
// rtl/pipe_reg_file.sv - dual-write dual-read register file with bypass and RAW scoreboard
module pipe_reg_file
    import cpu_pkg::*;
#(
    parameter int DATA_W   = CPU_DATA_W,
    parameter int ADDR_W   = CPU_ADDR_W,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              busy_a,
    output logic              busy_b,
    input  logic              wr0_en,
    input  logic [ADDR_W-1:0] wr0_addr,
    input  logic [DATA_W-1:0] wr0_data,
    input  logic              wr1_en,
    input  logic [ADDR_W-1:0] wr1_addr,
    input  logic [DATA_W-1:0] wr1_data,
    input  logic              iss_en,
    input  logic [ADDR_W-1:0] iss_addr,
    input  logic              flush
);

    localparam int NREGS = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];
    logic [ADDR_W-1:0] rd_addr [2];
    logic [DATA_W-1:0] rd_data [2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Port 1 is applied last so it owns a same-address collision
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (wr0_en) begin
            regs_d[wr0_addr] = wr0_data;
        end
        if (wr1_en) begin
            regs_d[wr1_addr] = wr1_data;
        end
        if (ZERO_REG != 0) begin
            regs_d[ZERO_ADDR] = '0;
        end
    end

    assign rd_addr[0] = rd_addr_a;
    assign rd_addr[1] = rd_addr_b;

    // Zero register and reset override any forwarded write data
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_data[p] = regs_q[rd_addr[p]];
            if (BYPASS != 0) begin
                if (wr0_en && (wr0_addr == rd_addr[p])) begin
                    rd_data[p] = wr0_data;
                end
                if (wr1_en && (wr1_addr == rd_addr[p])) begin
                    rd_data[p] = wr1_data;
                end
            end
            if ((ZERO_REG != 0) && (rd_addr[p] == ZERO_ADDR)) begin
                rd_data[p] = '0;
            end
            if (!rst_n) begin
                rd_data[p] = '0;
            end
        end
    end

    assign rd_data_a = rd_data[0];
    assign rd_data_b = rd_data[1];

    rf_scoreboard #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG),
        .BYPASS   (BYPASS)
    ) u_scoreboard (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .wr0_en    (wr0_en),
        .wr0_addr  (wr0_addr),
        .wr1_en    (wr1_en),
        .wr1_addr  (wr1_addr),
        .iss_en    (iss_en),
        .iss_addr  (iss_addr),
        .flush     (flush),
        .busy_a    (busy_a),
        .busy_b    (busy_b)
    );

endmodule
